// File: rtl/sr_wpl_pkg.sv
// sr_wpl_pkg: selection codes shared by the shift register and its bit cell.
package sr_wpl_pkg;
    typedef logic [1:0] sel_t;
    localparam sel_t SEL_HOLD = 2'd0;
    localparam sel_t SEL_LOAD = 2'd1;
    localparam sel_t SEL_SHL  = 2'd2;
    localparam sel_t SEL_SHR  = 2'd3;
endpackage

// File: rtl/sr_wpl_cell.sv
// sr_wpl_cell: one register bit, a 4:1 mux feeding a flop with synchronous clear.
module sr_wpl_cell
    import sr_wpl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  sel_t i_sel,
    input  logic i_load,
    input  logic i_shl,
    input  logic i_shr,
    output logic o_q
);
    logic r_q;
    logic w_d;
    always_comb begin
        w_d = (i_sel == SEL_LOAD) ? i_load :
              (i_sel == SEL_SHL)  ? i_shl  :
              (i_sel == SEL_SHR)  ? i_shr  : r_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) r_q <= 1'b0;
        else        r_q <= w_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/sr_wpl.sv
// sr_wpl: N-bit universal shift register (hold / parallel load / shift left / shift right).
module sr_wpl
    import sr_wpl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] data_in,
    input  sel_t         selection,
    input  logic         i_right,
    input  logic         i_left,
    output logic [N-1:0] data_out
);
    logic [N-1:0] w_q;
    // Serial fill bits enter at the ends; interior bits take their neighbours.
    logic [N+1:0] w_chain;
    assign w_chain = {i_left, w_q, i_right};
    for (genvar i = 0; i < N; i++) begin : g_bit
        sr_wpl_cell u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_sel  (selection),
            .i_load (data_in[i]),
            .i_shl  (w_chain[i]),
            .i_shr  (w_chain[i+2]),
            .o_q    (w_q[i])
        );
    end
    assign data_out = w_q;
endmodule

// File: tb/tb_sr_wpl.sv
// tb_sr_wpl: directed and randomized checks of sr_wpl against an arithmetic model.
module tb_sr_wpl;
    import sr_wpl_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    sel_t       selection;
    logic       i_right;
    logic       i_left;
    logic [7:0] data_out;
    int         total = 0;
    int         bad = 0;
    int         model;

    sr_wpl #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .selection (selection),
        .i_right   (i_right),
        .i_left    (i_left),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Next register value from the operation's arithmetic meaning.
    function automatic int ref_next(input int q, input int sel, input int d, input int ir, input int il);
        case (sel)
            1: return d;
            2: return (q * 2) % 256 + ir;
            3: return q / 2 + il * 128;
            default: return q;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; selection = SEL_LOAD; data_in = 8'hFF; i_right = 1'b1; i_left = 1'b1;
        step();
        chk("reset_wins", data_out, 8'h00);
        rst_n = 1'b1; data_in = 8'd100; i_right = 1'bx; i_left = 1'bx;
        step();
        chk("load_64", data_out, 8'h64);
        selection = SEL_SHL; i_right = 1'b1;
        step();
        chk("shl_1", data_out, 8'hC9);
        step();
        chk("shl_2", data_out, 8'h93);
        i_right = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("shl_flush", data_out, 8'h00);
        selection = SEL_LOAD; data_in = 8'h64;
        step();
        chk("reload_64", data_out, 8'h64);
        selection = SEL_SHR; i_left = 1'b1;
        step();
        chk("shr_1", data_out, 8'hB2);
        i_left = 1'b0;
        step();
        chk("shr_2", data_out, 8'h59);
        selection = SEL_HOLD;
        for (int i = 0; i < 4; i++) begin
            data_in = ~data_in; i_left = ~i_left; i_right = ~i_right;
            step();
            chk("hold", data_out, 8'h59);
        end
        model = 'h59;
        for (int c = 0; c < 1000; c++) begin
            selection = sel_t'($urandom_range(0, 3));
            data_in   = 8'($urandom);
            i_right   = 1'($urandom);
            i_left    = 1'($urandom);
            rst_n     = !(c == 500 || c == 501 || $urandom_range(0, 99) == 0);
            model = rst_n ? ref_next(model, int'(selection), int'(data_in), int'(i_right), int'(i_left)) : 0;
            step();
            chk(rst_n ? "rand" : "rand_reset", data_out, 8'(model));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
